// File: rtl/led_seq_pkg.sv
// Shared constants and types for the LED sequencer.
package led_seq_pkg;

  // Operating mode, selected by wdata[1:0] on a control write.
  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_SHIFT  = 2'b10,
    MODE_COUNT  = 2'b11
  } mode_t;

  // Register select values for the CPU write port.
  localparam logic SEL_DATA = 1'b0;
  localparam logic SEL_CTRL = 1'b1;

  // Rotate an 8-bit pattern left by one position.
  function automatic logic [7:0] rotl8(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

endpackage

// File: rtl/led_seq_if.sv
// CPU write port plus LED-register output port of the LED sequencer.
//
// Handshake: wr is a single-cycle write strobe qualified by sel/wdata.
// There is no ready; every write is accepted on the edge that samples it.
// led_we is a single-cycle strobe qualifying led_in for the LED register.
interface led_seq_if;
  import led_seq_pkg::*;

  logic        wr;
  logic        sel;
  logic [15:0] wdata;
  logic [15:0] led_in;
  logic        led_we;
  logic [1:0]  mode;
  logic        tick;

  modport master (
    output wr, sel, wdata,
    input  led_in, led_we, mode, tick
  );

  modport slave (
    input  wr, sel, wdata,
    output led_in, led_we, mode, tick
  );

endinterface

// File: rtl/led_prescaler.sv
// Pattern-step prescaler: counts 0..TICK_DIV-1 while enabled and flags the
// terminal count. Held at zero while disabled; clear restarts the period.
// TICK_DIV must be at least 2 and fit in CNT_W bits.
module led_prescaler #(
  parameter int TICK_DIV = 25_000_000,
  parameter int CNT_W    = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic step
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  assign step   = enable && w_last;

  // Counter: zero on reset/clear/disable, wraps at the terminal count.
  always_ff @(posedge clk) begin
    if (!reset || clear || !enable) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED sequencer: arbitrates CPU writes against a prescaler-paced pattern
// engine (blink / rotate / count) and drives a registered LED write port.
// Priority: control write > data write > pending control redisplay > step.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int CNT_W    = 25
) (
  input  logic   clk,
  input  logic   reset,
  led_seq_if.slave bus
);

  mode_t       r_mode;
  logic [7:0]  r_pat;
  logic        r_phase;
  logic        r_show;     // control write seen last cycle: redisplay pat
  logic [15:0] r_led_in;
  logic        r_led_we;
  logic        r_tick;

  mode_t       w_mode_nxt;
  logic [7:0]  w_pat_nxt;
  logic        w_phase_nxt;
  logic        w_show_nxt;
  logic [15:0] w_led_in_nxt;
  logic        w_led_we_nxt;
  logic        w_ctrl_wr;
  logic        w_data_wr;
  logic        w_step;
  logic        w_unused;

  assign w_ctrl_wr = bus.wr && (bus.sel == SEL_CTRL);
  assign w_data_wr = bus.wr && (bus.sel == SEL_DATA);
  assign w_unused  = ^bus.wdata[15:8];

  led_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (r_mode != MODE_MANUAL),
    .clear  (w_ctrl_wr),
    .step   (w_step)
  );

  // Next-state and output selection; a dropped step leaves pat/phase alone.
  always_comb begin
    w_mode_nxt   = r_mode;
    w_pat_nxt    = r_pat;
    w_phase_nxt  = r_phase;
    w_show_nxt   = 1'b0;
    w_led_we_nxt = 1'b0;
    w_led_in_nxt = r_led_in;
    if (w_ctrl_wr) begin
      w_mode_nxt  = mode_t'(bus.wdata[1:0]);
      w_phase_nxt = 1'b1;
      w_show_nxt  = 1'b1;
    end else if (w_data_wr) begin
      w_pat_nxt    = bus.wdata[7:0];
      w_led_we_nxt = 1'b1;
      w_led_in_nxt = {8'h00, bus.wdata[7:0]};
    end else if (r_show) begin
      w_led_we_nxt = 1'b1;
      w_led_in_nxt = {8'h00, r_pat};
    end else if (w_step) begin
      case (r_mode)
        MODE_BLINK: begin
          w_phase_nxt  = ~r_phase;
          w_led_we_nxt = 1'b1;
          w_led_in_nxt = ~r_phase ? {8'h00, r_pat} : 16'h0000;
        end
        MODE_SHIFT: begin
          w_pat_nxt    = rotl8(r_pat);
          w_led_we_nxt = 1'b1;
          w_led_in_nxt = {8'h00, rotl8(r_pat)};
        end
        MODE_COUNT: begin
          w_pat_nxt    = r_pat + 8'h01;
          w_led_we_nxt = 1'b1;
          w_led_in_nxt = {8'h00, r_pat + 8'h01};
        end
        default: begin
          w_led_we_nxt = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mode   <= MODE_MANUAL;
      r_pat    <= 8'h00;
      r_phase  <= 1'b0;
      r_show   <= 1'b0;
      r_led_in <= 16'h0000;
      r_led_we <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_mode   <= w_mode_nxt;
      r_pat    <= w_pat_nxt;
      r_phase  <= w_phase_nxt;
      r_show   <= w_show_nxt;
      r_led_in <= w_led_in_nxt;
      r_led_we <= w_led_we_nxt;
      r_tick   <= w_step;
    end
  end

  assign bus.led_in = r_led_in;
  assign bus.led_we = r_led_we;
  assign bus.mode   = r_mode;
  assign bus.tick   = r_tick;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed, table-driven bench for led_sequencer with TICK_DIV=4.
module tb_led_sequencer;

  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 3;
  localparam int NV       = 28;
  localparam int WINDOW   = 20;

  // One record: optional idle cycles, one driven cycle, then either the
  // cycle (1-based after the drive edge) of the expected led_we, or 0 for
  // "no led_we for WINDOW cycles while outputs hold".
  typedef struct {
    logic        rst_n;
    logic        wr;
    logic        sel;
    logic [15:0] wdata;
    int          pre;
    int          wait_k;
    logic [15:0] exp_in;
    logic [1:0]  exp_mode;
    logic        exp_tick;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  vec_t vecs[NV];

  led_seq_if bus();

  led_sequencer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_vectors();
    // MANUAL data write, then quiet
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'hAB5A, 0, 1, 16'h005A, 2'b00, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 0, 0, 16'h005A, 2'b00, 1'b0};
    // SHIFT from 81
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'h0081, 0, 1, 16'h0081, 2'b00, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 16'h0002, 0, 2, 16'h0081, 2'b10, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 0, 3, 16'h0003, 2'b10, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 0, 4, 16'h0006, 2'b10, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 0, 4, 16'h000C, 2'b10, 1'b1};
    // SHIFT wrap from 80
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 0, 2, 16'h000C, 2'b00, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 16'h0080, 0, 1, 16'h0080, 2'b00, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 16'h0002, 0, 2, 16'h0080, 2'b10, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 0, 3, 16'h0001, 2'b10, 1'b1};
    // COUNT wrap from FE
    vecs[11] = '{1'b1, 1'b1, 1'b1, 16'h0000, 0, 2, 16'h0001, 2'b00, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 16'h00FE, 0, 1, 16'h00FE, 2'b00, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 16'h0003, 0, 2, 16'h00FE, 2'b11, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 16'h0000, 0, 3, 16'h00FF, 2'b11, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 16'h0000, 0, 4, 16'h0000, 2'b11, 1'b1};
    // BLINK 3C with a data write colliding with a step
    vecs[16] = '{1'b1, 1'b1, 1'b1, 16'h0000, 0, 2, 16'h0000, 2'b00, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 16'h003C, 0, 1, 16'h003C, 2'b00, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 1'b1, 16'h0001, 0, 2, 16'h003C, 2'b01, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 16'h0000, 0, 3, 16'h0000, 2'b01, 1'b1};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 16'h0000, 0, 4, 16'h003C, 2'b01, 1'b1};
    vecs[21] = '{1'b1, 1'b1, 1'b0, 16'h0077, 3, 1, 16'h0077, 2'b01, 1'b1};
    vecs[22] = '{1'b1, 1'b0, 1'b0, 16'h0000, 0, 4, 16'h0000, 2'b01, 1'b1};
    // SHIFT from 77, reset exactly on a pending step, then MANUAL quiet
    vecs[23] = '{1'b1, 1'b1, 1'b1, 16'h0002, 0, 2, 16'h0077, 2'b10, 1'b0};
    vecs[24] = '{1'b1, 1'b0, 1'b0, 16'h0000, 0, 3, 16'h00EE, 2'b10, 1'b1};
    vecs[25] = '{1'b0, 1'b0, 1'b0, 16'h0000, 3, 0, 16'h0000, 2'b00, 1'b0};
    vecs[26] = '{1'b1, 1'b1, 1'b0, 16'h0000, 0, 1, 16'h0000, 2'b00, 1'b0};
    vecs[27] = '{1'b1, 1'b0, 1'b0, 16'h0000, 0, 0, 16'h0000, 2'b00, 1'b0};
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.wr    = 1'b0;
    bus.sel   = 1'b0;
    bus.wdata = 16'h0000;
    fill_vectors();

    // Reset held 3 cycles.
    repeat (3) next_cycle();
    check("rst led_in", 32'(bus.led_in), 32'h0);
    check("rst led_we", 32'(bus.led_we), 32'h0);
    check("rst mode",   32'(bus.mode),   32'h0);
    check("rst tick",   32'(bus.tick),   32'h0);

    // Idle after release: nothing moves in MANUAL.
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      next_cycle();
      check($sformatf("idle%0d led_in", c), 32'(bus.led_in), 32'h0);
      check($sformatf("idle%0d led_we", c), 32'(bus.led_we), 32'h0);
      check($sformatf("idle%0d mode", c),   32'(bus.mode),   32'h0);
    end

    // Table-driven sequences.
    for (int i = 0; i < NV; i++) begin
      for (int p = 0; p < vecs[i].pre; p++) begin
        next_cycle();
        check($sformatf("v%0d pre led_we", i), 32'(bus.led_we), 32'h0);
      end
      rst_n     = vecs[i].rst_n;
      bus.wr    = vecs[i].wr;
      bus.sel   = vecs[i].sel;
      bus.wdata = vecs[i].wdata;
      next_cycle();
      rst_n     = 1'b1;
      bus.wr    = 1'b0;
      bus.wdata = 16'h0000;
      if (vecs[i].wait_k == 0) begin
        for (int k = 1; k <= WINDOW; k++) begin
          check($sformatf("v%0d k%0d quiet led_we", i, k), 32'(bus.led_we), 32'h0);
          check($sformatf("v%0d k%0d hold led_in", i, k), 32'(bus.led_in), 32'(vecs[i].exp_in));
          check($sformatf("v%0d k%0d mode", i, k), 32'(bus.mode), 32'(vecs[i].exp_mode));
          check($sformatf("v%0d k%0d tick", i, k), 32'(bus.tick), 32'(vecs[i].exp_tick));
          if (k < WINDOW) next_cycle();
        end
      end else begin
        for (int k = 1; k < vecs[i].wait_k; k++) begin
          check($sformatf("v%0d k%0d early led_we", i, k), 32'(bus.led_we), 32'h0);
          next_cycle();
        end
        check($sformatf("v%0d led_we", i), 32'(bus.led_we), 32'h1);
        check($sformatf("v%0d led_in", i), 32'(bus.led_in), 32'(vecs[i].exp_in));
        check($sformatf("v%0d mode", i),   32'(bus.mode),   32'(vecs[i].exp_mode));
        check($sformatf("v%0d tick", i),   32'(bus.tick),   32'(vecs[i].exp_tick));
        // Strobe lasts exactly one cycle when nothing follows immediately.
        if (i + 1 < NV && vecs[i + 1].pre == 0 && vecs[i + 1].wr == 1'b0 && vecs[i + 1].rst_n == 1'b1) begin
          // Next record starts with an idle drive cycle; its first k checks led_we low.
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global timeout guard.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Controller that sits in front of ControladorLED-style LED registers and drives their `in` and `we` inputs.
- Arbitrates between CPU bus writes and an internal pattern engine (blink, rotate, count) paced by a prescaler.
- Lets software either write LED values directly or hand the LEDs to an autonomous pattern with a single control write.
- All outputs are registered, giving the downstream LED register a clean single-cycle write strobe.

Parameters:
- TICK_DIV, 25_000_000: clock cycles per pattern step. Legal range ≥ 2. Value 4 is used in simulation.
- CNT_W, 25: prescaler counter width. Must satisfy 2^CNT_W ≥ TICK_DIV.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset. reset=0 at a clk edge resets the block.
- wr  input  1  CPU write strobe, one cycle per write.
- sel  input  1  register select: 0 = pattern/data register, 1 = control register.
- wdata  input  16  CPU write data.
- led_in  output  16  value for the LED register `in` port. Bits [15:8] are always 0.
- led_we  output  1  single-cycle write enable to the LED register.
- mode  output  2  current mode, for status readback.
- tick  output  1  registered prescaler step pulse, for debug/verification.

Behaviour:
- Reset (reset=0 at clk edge): mode=MANUAL(00), pat=8'h00, phase=0, prescaler=0, led_in=16'h0000, led_we=0, tick=0.
- Modes, set by `wdata[1:0]` on a control write:
  - 00 MANUAL
  - 01 BLINK
  - 10 SHIFT
  - 11 COUNT
- Control write (wr=1, sel=1):
  - Next edge: mode ← `wdata[1:0]`, prescaler ← 0, phase ← 1.
  - One edge later: led_we=1 with led_in={8'h00, pat}. The current pattern is shown immediately in every mode.
- Data write (wr=1, sel=0):
  - pat ← `wdata[7:0]`.
  - Following cycle: led_we=1, led_in={8'h00, wdata[7:0]}, in every mode.
  - Latency from wr to led_we is 1 cycle.
  - `wdata[15:8]` is ignored.
- Prescaler:
  - Counts 0..TICK_DIV-1 when mode≠MANUAL and wraps to 0.
  - Internal step fires in the cycle prescaler==TICK_DIV-1.
  - `tick` output is that step registered, so it aligns with the led_we it causes.
  - In MANUAL the prescaler is held at 0 and no steps occur.
- On each step (mode≠MANUAL, no CPU write that cycle):
  - BLINK: phase ← ~phase. led_in = phase_new ? pat : 0. pat is unchanged.
  - SHIFT: pat ← {pat[6:0], pat[7]} (rotate left). led_in = new pat. pat=00 stays 00.
  - COUNT: pat ← pat+1, mod 256 (8'hFF → 8'h00). led_in = new pat.
  - led_we=1 on the cycle after the step. Step period is exactly TICK_DIV cycles.
- Simultaneous events:
  - Data write in the same cycle as a step: the CPU wins, the step is dropped, the prescaler keeps counting, and one led_we is issued with the CPU value.
  - Control write in the same cycle as a step: the control write wins and the step is dropped.
  - BLINK with a data write: phase is left unchanged.
  - A wr with an undefined sel never occurs, because sel is 1 bit.
- led_we is high for exactly 1 cycle per event and is never asserted 2 cycles in a row unless events occur on consecutive cycles.
- led_in holds its last value while led_we=0.
- Reset mid-pattern aborts immediately: a step pending in the same cycle is dropped and no led_we follows. Downstream LEDs are cleared by their own reset.

Decomposition:
- Package `led_seq_pkg`:
  - Mode constants MODE_MANUAL=2'b00, MODE_BLINK=2'b01, MODE_SHIFT=2'b10, MODE_COUNT=2'b11.
  - SEL_DATA=0, SEL_CTRL=1.
- Sub-module `led_prescaler`:
  - Parameters TICK_DIV, CNT_W.
  - Inputs clk, reset, enable, clear; output step.
  - Counter plus terminal-count detect.
- Top module contains mode/pat/phase registers, the priority mux and the output registers.

Test Plan:
- Reset held 3 cycles, then released with no writes for 50 cycles → led_in=0000, led_we=0, mode=00 throughout.
- Data write wdata=16'hAB5A in MANUAL → next cycle led_we=1, led_in=005A; no further led_we for 20 cycles.
- Data pat=81, then control 10 (SHIFT), TICK_DIV=4 → immediate we with 0081, then every 4 cycles 0003, 0006, 000C. Start with pat=80: 0080 → 0001 (wrap).
- Data pat=FE, control 11 (COUNT) → immediate 00FE, then 00FF, then 0000 at 4-cycle spacing.
- Data pat=3C, control 01 (BLINK) → 003C, 0000, 003C… every 4 cycles. A data write of 77 coinciding with a step → single we with 0077, and the next step shows 0000.
- Mid-SHIFT, assert reset for 1 cycle → next cycle led_we=0, mode=00, pat=00. Write 00 after release → no further steps.
